// File: rtl/iiitb_alu_pkg.sv
// iiitb_alu_pkg: opcodes, flag bit positions and FSM encoding shared by the ALU and its bench.
package iiitb_alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_ADDC = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
endpackage

// File: rtl/iiitb_alu_mul.sv
// iiitb_alu_mul: shift-add multiplier, one multiplier bit per cycle; holds its product once done.
module iiitb_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  assign done = cnt == CW'(WIDTH);
  // The first partial product is taken on the start edge so WIDTH edges cover all bits.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{WIDTH{1'b0}}, a} << 1;
      mplier <= b >> 1;
      cnt    <= CW'(1);
    end else if (cnt != '0 && !done) begin
      prod   <= prod + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
endmodule

// File: rtl/iiitb_alu_seq.sv
// iiitb_alu_seq: handshaked registered ALU with stored carry; IIITB_ALU_MUL_EN adds the iterative multiplier.
module iiitb_alu_seq
  import iiitb_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       flags,
  output logic             err,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  logic             accept, ld, free, cst, c_n, v_n, ill, upd;
  logic [OPW-1:0]   rop;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   add_s, sub_d, shl_w, shr_w, sra_w;
  logic [SW-1:0]    sh;
  assign free   = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
`ifdef IIITB_ALU_MUL_EN
  state_t             state, state_n;
  logic               start, done;
  logic [2*WIDTH-1:0] prod;
  assign start    = accept && op == OP_MUL;
  assign busy     = state == S_MUL;
  assign in_ready = state == S_IDLE && free;
  assign ld       = (accept && !start) || (busy && done && free);
  assign rop      = busy ? OP_MUL : op;
  iiitb_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(wb_clk_i), .rst(wb_rst_i), .start(start), .a(a), .b(b), .done(done), .prod(prod)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= S_IDLE;
    else state <= state_n;
  // A finished product waits in MUL until the output register can take it.
  always_comb begin
    state_n = state;
    state_n = start ? S_MUL : (busy && done && free) ? S_IDLE : state;
  end
`else
  assign busy     = 1'b0;
  assign in_ready = free;
  assign ld       = accept;
  assign rop      = op;
`endif
  assign sh    = b[SW-1:0];
  assign add_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, rop == OP_ADDC && cst};
  assign sub_d = {1'b0, a} - {1'b0, b};
  // Extra bit past the edge of each shift captures the last bit shifted out (0 for amount 0).
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;
  assign sra_w = $signed({a, 1'b0}) >>> sh;
  always_comb begin
    res = '0;
    c_n = 1'b0;
    v_n = 1'b0;
    ill = 1'b0;
    upd = 1'b0;
    case (rop)
      OP_ADD, OP_ADDC: begin
        res = add_s[WIDTH-1:0];
        c_n = add_s[WIDTH];
        v_n = a[WIDTH-1] == b[WIDTH-1] && add_s[WIDTH-1] != a[WIDTH-1];
        upd = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        res = sub_d[WIDTH-1:0];
        c_n = sub_d[WIDTH];
        v_n = a[WIDTH-1] != b[WIDTH-1] && sub_d[WIDTH-1] != a[WIDTH-1];
        upd = rop == OP_SUB;
      end
      OP_NOT:  res = ~a;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL: begin
        res = shl_w[WIDTH-1:0];
        c_n = shl_w[WIDTH];
        upd = 1'b1;
      end
      OP_SHR: begin
        res = shr_w[WIDTH:1];
        c_n = shr_w[0];
        upd = 1'b1;
      end
      OP_SRA: begin
        res = sra_w[WIDTH:1];
        c_n = sra_w[0];
        upd = 1'b1;
      end
`ifdef IIITB_ALU_MUL_EN
      OP_MUL: begin
        res = prod[WIDTH-1:0];
        c_n = |prod[2*WIDTH-1:WIDTH];
        upd = 1'b1;
      end
`endif
      default: ill = 1'b1;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      out_valid <= 1'b0;
      r         <= '0;
      flags     <= '0;
      err       <= 1'b0;
      cst       <= 1'b0;
    end else if (ld) begin
      out_valid <= 1'b1;
      r         <= res;
      flags     <= ill ? 4'b0 : {res[WIDTH-1], res == '0, c_n, v_n};
      err       <= ill;
      if (upd) cst <= c_n;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_iiitb_alu_seq.sv
// tb_iiitb_alu_seq: directed vectors into a scoreboard queue; a negedge monitor pops and compares each result.
module tb_iiitb_alu_seq;
  import iiitb_alu_pkg::*;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [3:0] op = '0;
  logic       in_ready, out_valid, err, busy;
  logic [7:0] r;
  logic [3:0] flags;
  typedef struct {logic [7:0] rv; logic [3:0] fv; logic ev;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, last_wait = 0;

  always #5 clk = ~clk;

  iiitb_alu_seq #(.WIDTH(8), .OPW(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .flags(flags), .err(err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got r=%0h with empty scoreboard at %0t", r, $time);
      end else begin
        e = q.pop_front();
        chk("r", r, e.rv);
        chk("flags", flags, e.fv);
        chk("err", err, e.ev);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] er, input logic [3:0] ef, input logic ee, input bit push);
    int n = 0;
    bit acc = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    if (push) q.push_back('{er, ef, ee});
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    last_wait = n;
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: op %0d not accepted, got in_ready=0, expected 1", o);
    end
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_r", r, 0);
    chk("reset_flags", flags, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    idle(1);
    send(OP_ADD,  8'hF0, 8'h20, 8'h10, 4'b0010, 0, 1);
    send(OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0001, 0, 1);
    send(OP_CMP,  8'h01, 8'h02, 8'hFF, 4'b1010, 0, 1);
    send(OP_ADDC, 8'h00, 8'h00, 8'h00, 4'b0100, 0, 1);
    send(OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b0110, 0, 1);
    send(OP_ADDC, 8'h00, 8'h00, 8'h01, 4'b0000, 0, 1);
    chk("back_to_back_accept", last_wait, 1);
    send(OP_NOT,  8'h0F, 8'h00, 8'hF0, 4'b1000, 0, 1);
    send(OP_NAND, 8'hF0, 8'h3C, 8'hCF, 4'b1000, 0, 1);
    send(OP_NOR,  8'hF0, 8'h0F, 8'h00, 4'b0100, 0, 1);
    send(OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000, 0, 1);
    send(OP_OR,   8'h80, 8'h01, 8'h81, 4'b1000, 0, 1);
    send(OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b1001, 0, 1);
    send(OP_SUB,  8'h05, 8'h07, 8'hFE, 4'b1010, 0, 1);
    send(OP_SHR,  8'h81, 8'h03, 8'h10, 4'b0000, 0, 1);
    send(OP_SHR,  8'h85, 8'h03, 8'h10, 4'b0010, 0, 1);
    send(OP_SRA,  8'h80, 8'h04, 8'hF8, 4'b1000, 0, 1);
    send(OP_SRA,  8'h80, 8'h00, 8'h80, 4'b1000, 0, 1);
    send(OP_SHL,  8'h40, 8'h09, 8'h80, 4'b1000, 0, 1);
    send(OP_SHL,  8'h81, 8'h01, 8'h02, 4'b0010, 0, 1);
    send(4'd14,   8'h12, 8'h34, 8'h00, 4'b0000, 1, 1);
    send(4'd15,   8'hFF, 8'hFF, 8'h00, 4'b0000, 1, 1);
    send(OP_ADDC, 8'h00, 8'h00, 8'h01, 4'b0000, 0, 1);
    idle(1);
    out_ready = 1'b0;
    send(OP_XOR, 8'hAA, 8'hFF, 8'h55, 4'b0000, 0, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_r", r, 8'h55);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000, 0, 1);
    chk("accept_on_out_ready_rise", last_wait, 1);
`ifdef IIITB_ALU_MUL_EN
    send(OP_MUL, 8'h0D, 8'h0B, 8'h8F, 4'b1000, 0, 1);
    repeat (8) begin
      @(negedge clk);
      chk("mul_pending_out_valid", out_valid, 0);
      chk("mul_busy", busy, 1);
      chk("mul_in_ready", in_ready, 0);
    end
    @(negedge clk);
    chk("mul_done_out_valid", out_valid, 1);
    chk("mul_done_busy", busy, 0);
    idle(1);
    send(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0110, 0, 1);
    idle(12);
    send(OP_MUL, 8'h0D, 8'h0B, 8'h00, 4'b0000, 0, 0);
    idle(3);
`else
    send(OP_MUL, 8'h0D, 8'h0B, 8'h00, 4'b0000, 1, 1);
    @(negedge clk);
    chk("mul_disabled_busy", busy, 0);
    idle(1);
    send(OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010, 0, 1);
    idle(1);
`endif
    pulse_reset();
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_out_valid", out_valid, 0);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_in_ready", in_ready, 1);
    end
    idle(1);
    send(OP_ADDC, 8'h00, 8'h00, 8'h00, 4'b0100, 0, 1);
    idle(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
